// File: rtl/ssd_frame_decoder.sv
// ---------------------------------------------------------------------------
// ssd_frame_decoder
//
// Receives a two-digit multiplexed seven-segment display bus and recovers the
// shown value as BCD. Every {CA,AN} sample must stay unchanged for SETTLE
// cycles before it is accepted, which filters out mux glitches. A ones digit
// followed by a tens digit forms one frame. Illegal glyphs are flagged. A scan
// that stops toggling CA raises STALL.
//
// Parameters
//   SETTLE    : cycles a sample must hold before acceptance (2..255)
//   STALL_CYC : cycles without a CA change before STALL asserts (>= 4)
// Ports
//   CLK     in   clock, rising edge
//   RST     in   synchronous active-high reset
//   AN[6:0] in   segment pattern, bit0 = a .. bit6 = g, active-high
//   CA      in   digit select, 0 = ones, 1 = tens
//   ONES    out  last framed ones digit (BCD)
//   TENS    out  last framed tens digit (BCD, 4'hF = blank)
//   VALID   out  one-cycle pulse, ONES/TENS updated this cycle
//   CHANGED out  pulse with VALID when the frame differs from the previous one
//   ERR     out  one-cycle pulse when an illegal glyph is accepted
//   STALL   out  level, scan stalled
// ---------------------------------------------------------------------------
module ssd_frame_decoder #(
    parameter int SETTLE    = 8,
    parameter int STALL_CYC = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] AN,
    input  logic       CA,
    output logic [3:0] ONES,
    output logic [3:0] TENS,
    output logic       VALID,
    output logic       CHANGED,
    output logic       ERR,
    output logic       STALL
);

    localparam int SCW = $clog2(SETTLE + 1);
    localparam int TCW = $clog2(STALL_CYC + 1);
    localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE);
    localparam logic [SCW-1:0] SETTLE_HIT = SCW'(SETTLE - 1);
    localparam logic [TCW-1:0] STALL_MAX  = TCW'(STALL_CYC);

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        WAIT_TENS = 2'd1,
        WAIT_ONES = 2'd2
    } state_t;

    // Returns {legal, digit}. Blank is only legal on the tens position.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg, input logic is_tens);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b1, 4'd0};
            7'h06:   res = {1'b1, 4'd1};
            7'h5B:   res = {1'b1, 4'd2};
            7'h4F:   res = {1'b1, 4'd3};
            7'h66:   res = {1'b1, 4'd4};
            7'h6D:   res = {1'b1, 4'd5};
            7'h7D:   res = {1'b1, 4'd6};
            7'h07:   res = {1'b1, 4'd7};
            7'h7F:   res = {1'b1, 4'd8};
            7'h6F:   res = {1'b1, 4'd9};
            7'h00:   res = {is_tens, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic           ca_r, ca_prev_r;
    logic [6:0]     an_r, an_prev_r;
    logic [SCW-1:0] settle_cnt_r;
    logic [TCW-1:0] stall_cnt_r, stall_cnt_nxt_s;
    logic           stall_r;
    state_t         state_r;
    logic [3:0]     pend_r, ones_r, tens_r;
    logic           valid_r, changed_r, err_r;
    logic           sample_diff_s, ca_chg_s, accept_s;
    logic [4:0]     dec_s;

    // Input registration plus one-deep history for change detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ca_r      <= 1'b0;
            an_r      <= 7'h00;
            ca_prev_r <= 1'b0;
            an_prev_r <= 7'h00;
        end else begin
            ca_r      <= CA;
            an_r      <= AN;
            ca_prev_r <= ca_r;
            an_prev_r <= an_r;
        end
    end

    // Change detection, acceptance strobe and glyph decode of the settled sample.
    // The counter only passes through SETTLE-1 once per stable run, so this
    // fires exactly once per run; the settled value is the history register.
    always_comb begin
        sample_diff_s = ({ca_r, an_r} != {ca_prev_r, an_prev_r});
        ca_chg_s      = (ca_r != ca_prev_r);
        accept_s      = (settle_cnt_r == SETTLE_HIT);
        dec_s         = glyph_decode(an_prev_r, ca_prev_r);
        if (stall_cnt_r == STALL_MAX) begin
            stall_cnt_nxt_s = STALL_MAX;
        end else begin
            stall_cnt_nxt_s = stall_cnt_r + TCW'(1);
        end
    end

    // Stability counter, saturating at SETTLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_cnt_r <= '0;
        end else if (sample_diff_s) begin
            settle_cnt_r <= '0;
        end else if (settle_cnt_r != SETTLE_MAX) begin
            settle_cnt_r <= settle_cnt_r + SCW'(1);
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Stall counter and flag; a CA change takes priority over the threshold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_r <= '0;
            stall_r     <= 1'b0;
        end else if (ca_chg_s) begin
            stall_cnt_r <= '0;
            stall_r     <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_nxt_s;
            stall_r     <= (stall_cnt_nxt_s == STALL_MAX);
        end
    end

    // Frame assembly FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= SYNC;
            pend_r    <= 4'h0;
            ones_r    <= 4'h0;
            tens_r    <= 4'h0;
            valid_r   <= 1'b0;
            changed_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            valid_r   <= 1'b0;
            changed_r <= 1'b0;
            err_r     <= 1'b0;
            if (accept_s) begin
                if (!dec_s[4]) begin
                    err_r   <= 1'b1;
                    pend_r  <= 4'h0;
                    state_r <= WAIT_ONES;
                end else if (!ca_prev_r) begin
                    pend_r  <= dec_s[3:0];
                    state_r <= WAIT_TENS;
                end else begin
                    case (state_r)
                        WAIT_TENS: begin
                            ones_r    <= pend_r;
                            tens_r    <= dec_s[3:0];
                            valid_r   <= 1'b1;
                            changed_r <= ({dec_s[3:0], pend_r} != {tens_r, ones_r});
                            state_r   <= WAIT_ONES;
                        end
                        SYNC, WAIT_ONES: state_r <= state_r;
                        default:         state_r <= SYNC;
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign ONES    = ones_r;
    assign TENS    = tens_r;
    assign VALID   = valid_r;
    assign CHANGED = changed_r;
    assign ERR     = err_r;
    assign STALL   = stall_r;

endmodule

// File: doc/ssd_frame_decoder.md
# ssd_frame_decoder

Recovers the two-digit value shown on the stopwatch's multiplexed seven-segment bus (segment lines `AN[6:0]`, digit select `CA`) and presents it as BCD with a frame strobe. It sits on the receiving side of that display bus. In simulation it is the self-checking monitor for `my_Stopwatch`; on the board it is a loopback checker. It tolerates mux glitches by requiring a settled pattern, rejects illegal glyphs, and flags a stopped scan.

## Interface
- `SETTLE`, default 8: consecutive identical cycles a `{CA,AN}` sample must hold before it is accepted; legal range 2..255.
- `STALL_CYC`, default 1_000_000: number of cycles with no `CA` change after which `STALL` asserts; minimum 4.
- `CLK`, input, 1: single clock; all logic is on the rising edge.
- `RST`, input, 1: reset, synchronous and active-high.
- `AN`, input, 7: segment pattern, active-high; bit 0 = a through bit 6 = g.
- `CA`, input, 1: digit select; 0 = ones digit, 1 = tens digit.
- `ONES`, output, 4: last framed ones digit, BCD.
- `TENS`, output, 4: last framed tens digit, BCD; 4'hF = blank.
- `VALID`, output, 1: one-cycle pulse; `ONES`/`TENS` updated this cycle.
- `CHANGED`, output, 1: one-cycle pulse coincident with `VALID` when the frame differs from the previous frame.
- `ERR`, output, 1: one-cycle pulse when an illegal glyph is accepted.
- `STALL`, output, 1: level; scan stalled.

## Operation
- The inputs are registered once into `r_ca` and `r_an`. A stability counter resets to 0 whenever `{r_ca,r_an}` differs from the previous registered sample, and saturates at `SETTLE`.
- A sample is accepted exactly once per stable run, in the cycle the counter reaches `SETTLE-1`. A later change followed by a new stable run permits a new acceptance.
- Glyph decode is fixed:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 = blank, which is legal on the tens digit only and decodes to F.
  - Every other pattern, and blank on the ones digit, is illegal.
- FSM states and transitions:
  - SYNC is entered on reset. An accepted ones digit latches a pending ones value and moves to WAIT_TENS. An accepted tens digit is ignored.
  - WAIT_TENS: an accepted ones digit overwrites the pending value and the FSM stays. An accepted tens digit loads `ONES` from pending and `TENS` from the decode, pulses `VALID`, and moves to WAIT_ONES.
  - WAIT_ONES behaves like SYNC, except that a tens digit is ignored silently.
- An illegal accepted glyph pulses `ERR`, leaves `ONES`/`TENS` unchanged, drops any pending value, and forces WAIT_ONES. This applies in any state.
- `CHANGED` pulses with `VALID` when the new `{TENS,ONES}` differs from the held value. The first frame after reset compares against 0x00.
- `STALL` uses a cycle counter that resets on any change of `r_ca`. `STALL` is 1 while the counter is at or above `STALL_CYC`. It clears in the cycle after the next `r_ca` change. The FSM state is unaffected by `STALL`.

## Timing
- When `RST`=1 at an edge, the next cycle has:
  - `ONES`=0, `TENS`=0, `VALID`=0, `CHANGED`=0, `ERR`=0, `STALL`=0
  - FSM in SYNC, with all counters and `r_*` registers cleared.
- Reset asserted mid-frame discards the pending value. No `VALID` is produced for that frame.
- Acceptance latency: with `{CA,AN}` driven constant from edge t, acceptance occurs at edge t+`SETTLE`. `VALID`, `ERR` and updated outputs are visible after edge t+`SETTLE`+1.
- A run shorter than `SETTLE` cycles is never accepted.
- `VALID` and `ERR` are never high in the same cycle. At most one of them pulses per acceptance.
- Simultaneous `r_ca` change and `STALL` threshold: the change wins, so `STALL` stays 0.
- The stall counter saturates and does not wrap.

## Test plan
Run with `SETTLE`=4, `STALL_CYC`=64.
- **Basic frame:** reset, then drive `CA`=0/`AN`=6D for 10 cycles, then `CA`=1/`AN`=5B for 10 cycles -> one `VALID` with `ONES`=5, `TENS`=2, and `CHANGED`=1, timed at acceptance +1 cycle.
- **Glitch rejection:** hold `CA`=0 with `AN`=7F for 3 cycles, then 06 for 10 cycles, then tens 3F -> only digit 1 is accepted; frame is `TENS`=0, `ONES`=1.
- **Blank and illegal glyphs:**
  - Ones 4F, then tens 00 -> `TENS`=F, `ONES`=3.
  - Ones 00 -> `ERR` pulse, no `VALID`, outputs held.
  - Ones 12 -> `ERR` pulse, no `VALID`, outputs held.
- **Sync and repeat:**
  - After reset, tens 06 first -> ignored.
  - Then ones 07, ones 66, tens 06 -> a single frame of 14.
  - Repeat the same frame -> `VALID`=1 with `CHANGED`=0.
- **Stall:** hold `CA` constant for 70 cycles -> `STALL` rises when the counter reaches 64. Toggle `CA` -> `STALL` falls on the next cycle.
- **Reset mid-frame:** accept ones 66, assert `RST` for 1 cycle, then tens 5B -> no `VALID`, all outputs 0.
